iq_interpolator: RTL
====================

# iq_interpolator

Symbol-to-sample stage downstream of the IQ clock-domain-crossing FIFO in the `sym_clk` domain. Pops packed {I,Q} 64-QAM symbols from the FIFO read port and emits OSR samples per symbol by linear interpolation between consecutive symbols. Output goes to the DAC/pulse-shaping path under a valid/ready handshake. On FIFO starvation the block ramps the output to zero.

## Interface
- `OSR_LOG2`, default 2: oversampling ratio is OSR = 2^OSR_LOG2, legal range 1..4.
- `SW`, default 4+OSR_LOG2: sample width; derived, not overridden.
- `sym_clk`  in  1  symbol clock; the only clock.
- `rst_n_sym`  in  1  asynchronous active-low reset.
- `IQ_empty`  in  1  FIFO empty flag.
- `IQ_data_out`  in  8  FIFO read data: [7:4] = I, [3:0] = Q. Each is 4-bit two's complement with odd levels −7..+7.
- `IQ_rd_en`  out  1  FIFO pop strobe.
- `sample_ready`  in  1  downstream accepts the sample this cycle.
- `sample_valid`  out  1  `I_sample`/`Q_sample` are valid.
- `I_sample`  out  SW  signed interpolated I sample.
- `Q_sample`  out  SW  signed interpolated Q sample.
- `underrun`  out  1  one-cycle pulse when a symbol boundary finds no symbol available.
- `underrun_cnt`  out  8  saturating underrun count; present only with `IQ_INTERP_UNDERRUN_CNT_EN`.

## Operation
- Registers:
  - `prev` and `cur` are {I,Q} pairs.
  - `nxt` is the prefetch buffer, with flag `nxt_valid`.
  - `k` is the phase counter, 0..OSR-1.
  - `starved` is a 1-bit flag.
- Prefetch:
  - `IQ_rd_en` = !`IQ_empty` && !`nxt_valid` && !`rd_pending`.
  - The read port has a 1-cycle latency: data is captured into `nxt` the cycle after the pop, and `nxt_valid` is set.
  - At most one read is outstanding.
- Sample value:
  - `I_sample` = prev_I·(OSR−k) + cur_I·k, using full-width signed arithmetic. There is no division; the output is scaled by OSR.
  - Magnitude is at most 7·OSR < 2^(SW−1), so the result never overflows.
  - `Q_sample` uses the same formula on the Q components.
- States:
  - **IDLE**: `sample_valid`=0. When `nxt_valid`=1: `prev`←0, `cur`←`nxt`, `nxt_valid`←0, `k`←0, `starved`←0, go to RUN.
  - **RUN**: `sample_valid`=1.
    - On an accepted sample (valid && ready) with k<OSR−1: k←k+1.
    - When ready is low, all registers hold.
  - **RUN boundary**: accepted sample with k=OSR−1.
    - In all cases: k←0, `prev`←`cur`.
    - If `nxt_valid`: `cur`←`nxt`, `nxt_valid`←0, `starved`←0.
    - Else if !`starved`: `cur`←0, `starved`←1, pulse `underrun`.
    - Else (second consecutive empty boundary, output has settled at zero): go to IDLE, pulse `underrun`.
- Simultaneous events:
  - A boundary consuming `nxt` in the same cycle that read data arrives cannot occur, because at most one read is outstanding.
  - If read data lands in the same cycle as a starved boundary, the boundary uses the empty path. The new symbol is used at the next boundary, or on IDLE exit.
- Reset mid-operation:
  - All state clears immediately and the FIFO handshake aborts; a pending read is discarded.
  - The FIFO is reset in the same domain.

## Timing
- Reset values:
  - `IQ_rd_en`=0, `sample_valid`=0, `I_sample`=`Q_sample`=0, `underrun`=0, `underrun_cnt`=0.
  - State = IDLE, with all data registers at 0.
- Outputs are registered except `IQ_rd_en`, which is combinational from registered state and `IQ_empty`.
- Start-up latency from the FIFO becoming non-empty:
  - Cycle t: `IQ_rd_en`.
  - Cycle t+1: data captured.
  - Cycle t+2: `nxt_valid`; IDLE→RUN at the end of this cycle.
  - Cycle t+3: first `sample_valid`.
- Sustained throughput is 1 symbol per OSR cycles with no bubbles, provided the FIFO is not empty at least 2 cycles before each boundary.
- Symbol n reaches full weight (k=0 of the interval after it is loaded) OSR accepted samples after it becomes `cur`.

## Configuration
- `IQ_INTERP_UNDERRUN_CNT_EN`
  - Defined: the `underrun_cnt` port exists. It increments on each `underrun` pulse, saturates at 255, and clears only on reset.
  - Undefined: the port and its counter are absent; `underrun` is still generated.

## Test plan
- **Start-up**
  - Stimulus: OSR_LOG2=2; push I=+3,Q=−1 into the FIFO.
  - Required: `IQ_rd_en` pulses once; first `sample_valid` appears 3 cycles later.
  - Required: I samples 0, 3, 6, 9; Q samples 0, −1, −2, −3.
- **Interpolation**
  - Stimulus: follow with I=−5; keep `sample_ready`=1.
  - Required: next I samples 12, 4, −4, −12, then −20.
- **Backpressure**
  - Stimulus: drop `sample_ready` for 5 cycles mid-interval.
  - Required: samples and k hold; no extra FIFO pops; the sequence resumes unchanged.
- **Starvation**
  - Stimulus: single symbol I=+7, then the FIFO stays empty.
  - Required: I goes 0, 7, 14, 21, then 28, 21, 14, 7.
  - Required: `underrun` pulses twice; the block returns to IDLE with `sample_valid`=0.
- **Reset mid-run**
  - Stimulus: assert `rst_n_sym` at k=2.
  - Required: all outputs are 0 asynchronously; after release, restart follows the start-up latency.
- **Counter (macro defined)**
  - Stimulus: 300 starved boundaries.
  - Required: `underrun_cnt` saturates at 255.

Source files
------------

// File: rtl/iq_interpolator.sv
// Symbol-to-sample interpolator: prefetches {I,Q} symbols from the IQ FIFO and emits
// 2^OSR_LOG2 linearly interpolated samples per symbol. Optional macro: IQ_INTERP_UNDERRUN_CNT_EN.
module iq_interpolator #(
    parameter  int OSR_LOG2 = 2,
    localparam int SW       = 4 + OSR_LOG2
) (
    input  logic                 sym_clk,
    input  logic                 rst_n_sym,
    input  logic                 IQ_empty,
    input  logic [7:0]           IQ_data_out,
    output logic                 IQ_rd_en,
    input  logic                 sample_ready,
    output logic                 sample_valid,
    output logic signed [SW-1:0] I_sample,
    output logic signed [SW-1:0] Q_sample,
    output logic                 underrun
`ifdef IQ_INTERP_UNDERRUN_CNT_EN
    ,
    output logic [7:0]           underrun_cnt
`endif
);

    localparam int                  OSR    = 1 << OSR_LOG2;
    localparam int                  AW     = SW + 2;
    localparam logic [OSR_LOG2-1:0] K_LAST = OSR_LOG2'(OSR - 1);

    typedef enum logic {IDLE, RUN} state_t;

    typedef struct packed {
        logic signed [3:0] i;
        logic signed [3:0] q;
    } iq_t;

    state_t              state, state_d;
    iq_t                 prev, prev_d, cur, cur_d, nxt;
    logic                nxt_valid, nxt_valid_d;
    logic                rd_pending;
    logic [OSR_LOG2-1:0] k, k_d;
    logic                starved, starved_d;
    logic                underrun_d;
    logic signed [SW-1:0] i_sample_d, q_sample_d;

    // Weighted sum a*(OSR-k) + b*k; |result| <= 7*OSR always fits in SW bits.
    function automatic logic signed [SW-1:0] interp(input logic signed [3:0] a,
                                                    input logic signed [3:0] b,
                                                    input logic [OSR_LOG2-1:0] kk);
        logic signed [AW-1:0] ax, bx, wa, wb, acc;
        ax  = AW'(a);
        bx  = AW'(b);
        wb  = AW'(kk);
        wa  = AW'(OSR) - wb;
        acc = ax * wa + bx * wb;
        return acc[SW-1:0];
    endfunction

    // At most one read in flight, and only when the prefetch slot is free.
    assign IQ_rd_en = !IQ_empty && !nxt_valid && !rd_pending;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        state_d     = state;
        prev_d      = prev;
        cur_d       = cur;
        nxt_valid_d = nxt_valid;
        k_d         = k;
        starved_d   = starved;
        underrun_d  = 1'b0;

        if (rd_pending) nxt_valid_d = 1'b1;

        case (state)
            IDLE: begin
                if (nxt_valid) begin
                    prev_d      = '0;
                    cur_d       = nxt;
                    nxt_valid_d = 1'b0;
                    k_d         = '0;
                    starved_d   = 1'b0;
                    state_d     = RUN;
                end
            end
            RUN: begin
                if (sample_valid && sample_ready) begin
                    if (k != K_LAST) begin
                        k_d = k + OSR_LOG2'(1);
                    end else begin
                        k_d    = '0;
                        prev_d = cur;
                        if (nxt_valid) begin
                            cur_d       = nxt;
                            nxt_valid_d = 1'b0;
                            starved_d   = 1'b0;
                        end else if (!starved) begin
                            // First empty boundary: ramp toward zero over one interval.
                            cur_d      = '0;
                            starved_d  = 1'b1;
                            underrun_d = 1'b1;
                        end else begin
                            state_d    = IDLE;
                            underrun_d = 1'b1;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        i_sample_d = '0;
        q_sample_d = '0;
        if (state_d == RUN) begin
            i_sample_d = interp(prev_d.i, cur_d.i, k_d);
            q_sample_d = interp(prev_d.q, cur_d.q, k_d);
        end
    end

    // Outputs are registered from next-state values so they line up with the state.
    always_ff @(posedge sym_clk or negedge rst_n_sym) begin
        if (!rst_n_sym) begin
            state        <= IDLE;
            prev         <= '0;
            cur          <= '0;
            nxt          <= '0;
            nxt_valid    <= 1'b0;
            rd_pending   <= 1'b0;
            k            <= '0;
            starved      <= 1'b0;
            sample_valid <= 1'b0;
            I_sample     <= '0;
            Q_sample     <= '0;
            underrun     <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all flops update together.
            state        <= state_d;
            prev         <= prev_d;
            cur          <= cur_d;
            nxt_valid    <= nxt_valid_d;
            rd_pending   <= IQ_rd_en;
            k            <= k_d;
            starved      <= starved_d;
            sample_valid <= (state_d == RUN);
            I_sample     <= i_sample_d;
            Q_sample     <= q_sample_d;
            underrun     <= underrun_d;
            if (rd_pending) nxt <= iq_t'(IQ_data_out);
        end
    end

`ifdef IQ_INTERP_UNDERRUN_CNT_EN
    always_ff @(posedge sym_clk or negedge rst_n_sym) begin
        if (!rst_n_sym) begin
            underrun_cnt <= '0;
        end else if (underrun_d && underrun_cnt != 8'hFF) begin
            underrun_cnt <= underrun_cnt + 8'd1;
        end
    end
`else
    // Without the counter only the underrun pulse is reported.
`endif

endmodule
